// File: rtl/cv32e40x_rvfi_pkg.sv
// rtl/cv32e40x_rvfi_pkg.sv - shared types and limits for the RVFI memory-trace collector
// Contents:
//   RVFI_NMEM_MAX     upper bound on memory slots per retired instruction
//   rvfi_mem_entry_t  one tracked OBI transaction (request side only; response errors
//                     are never stored here, they are captured with the response)
package cv32e40x_rvfi_pkg;

  localparam int RVFI_NMEM_MAX = 16;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        discard;  // response still gets popped, but is not traced
  } rvfi_mem_entry_t;

endpackage

// File: rtl/cv32e40x_rvfi_mem_fifo.sv
// rtl/cv32e40x_rvfi_mem_fifo.sv - DEPTH-entry tracker of outstanding OBI transactions
// Ports:
//   clk, rst_n     core clock, asynchronous active-low reset
//   push_i         write push_entry_i at the tail (caller guarantees room or a same-cycle pop)
//   push_entry_i   entry to store
//   pop_i          drop the head entry (caller guarantees not empty)
//   flush_i        mark every stored entry discard=1; an entry pushed this cycle is kept as given
//   head_o         oldest entry (value before this cycle's flush marking)
//   full_o         occupancy == DEPTH
//   empty_o        occupancy == 0
module cv32e40x_rvfi_mem_fifo
  import cv32e40x_rvfi_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push_i,
  input  rvfi_mem_entry_t push_entry_i,
  input  logic            pop_i,
  input  logic            flush_i,
  output rvfi_mem_entry_t head_o,
  output logic            full_o,
  output logic            empty_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  rvfi_mem_entry_t mem [DEPTH];
  logic [PW-1:0]   wptr;
  logic [PW-1:0]   rptr;
  logic [CW-1:0]   occ;

  // Explicit wrap so non-power-of-2 or DEPTH=1 builds stay correct.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign head_o  = mem[rptr];
  assign full_o  = (occ == CW'(DEPTH));
  assign empty_o = (occ == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      occ  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (flush_i) begin
        for (int i = 0; i < DEPTH; i++) begin
          mem[i].discard <= 1'b1;
        end
      end
      // Placed after the flush marking so a same-cycle push keeps discard=0.
      if (push_i) begin
        mem[wptr] <= push_entry_i;
        wptr      <= ptr_inc(wptr);
      end
      if (pop_i) begin
        rptr <= ptr_inc(rptr);
      end
      case ({push_i, pop_i})
        2'b10:   occ <= occ + CW'(1);
        2'b01:   occ <= occ - CW'(1);
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: rtl/cv32e40x_rvfi_mem_trace.sv
// rtl/cv32e40x_rvfi_mem_trace.sv - multi-slot RVFI memory-trace collector snooping the OBI data port
// Optional feature macro: CV32E40X_RVFI_MEM_ERR_EN (per-slot bus-error capture; erroring loads report rdata 0)
// Ports:
//   clk, rst_n                 core clock, asynchronous active-low reset
//   data_req_i .. data_wdata_i OBI request channel (accept = req & gnt)
//   data_rvalid_i/rdata/err    OBI response channel
//   wb_retire_i, wb_flush_i    retirement and pipeline flush from WB
//   rvfi_mem_valid_o           1-cycle pulse the cycle after a retirement
//   rvfi_mem_cnt_o             number of slots used
//   rvfi_mem_addr/rmask/wmask/rdata/wdata/err_o  NMEM packed slots, slot 0 = first response
//   rvfi_mem_ovf_o             more than NMEM responses were bound to the instruction
//   proto_err_o                sticky OBI protocol violation
module cv32e40x_rvfi_mem_trace
  import cv32e40x_rvfi_pkg::*;
#(
  parameter int NMEM  = 4,
  parameter int DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      data_req_i,
  input  logic                      data_gnt_i,
  input  logic [31:0]               data_addr_i,
  input  logic                      data_we_i,
  input  logic [3:0]                data_be_i,
  input  logic [31:0]               data_wdata_i,
  input  logic                      data_rvalid_i,
  input  logic [31:0]               data_rdata_i,
  input  logic                      data_err_i,
  input  logic                      wb_retire_i,
  input  logic                      wb_flush_i,
  output logic                      rvfi_mem_valid_o,
  output logic [$clog2(NMEM+1)-1:0] rvfi_mem_cnt_o,
  output logic [NMEM*32-1:0]        rvfi_mem_addr_o,
  output logic [NMEM*4-1:0]         rvfi_mem_rmask_o,
  output logic [NMEM*4-1:0]         rvfi_mem_wmask_o,
  output logic [NMEM*32-1:0]        rvfi_mem_rdata_o,
  output logic [NMEM*32-1:0]        rvfi_mem_wdata_o,
  output logic [NMEM-1:0]           rvfi_mem_err_o,
  output logic                      rvfi_mem_ovf_o,
  output logic                      proto_err_o
);

  localparam int CW = $clog2(NMEM + 1);
  localparam logic [CW-1:0] NMEM_C = CW'(NMEM);

  rvfi_mem_entry_t push_entry;
  rvfi_mem_entry_t head;
  logic            full;
  logic            empty;
  logic            accept;
  logic            push;
  logic            pop;
  logic            append;

  assign accept = data_req_i & data_gnt_i;
  assign pop    = data_rvalid_i & ~empty;
  // A full tracker still accepts when the head leaves in the same cycle.
  assign push   = accept & (~full | pop);
  assign append = pop & ~head.discard;

  assign push_entry = '{addr: data_addr_i, we: data_we_i, be: data_be_i,
                        wdata: data_wdata_i, discard: 1'b0};

  cv32e40x_rvfi_mem_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_i       (push),
    .push_entry_i (push_entry),
    .pop_i        (pop),
    .flush_i      (wb_flush_i),
    .head_o       (head),
    .full_o       (full),
    .empty_o      (empty)
  );

  // Accumulator for the instruction currently in flight, plus its next value
  // with this cycle's response folded in (also what a retirement reports).
  logic [CW-1:0]      acc_cnt,   nxt_cnt;
  logic               acc_ovf,   nxt_ovf;
  logic [NMEM*32-1:0] acc_addr,  nxt_addr;
  logic [NMEM*4-1:0]  acc_rmask, nxt_rmask;
  logic [NMEM*4-1:0]  acc_wmask, nxt_wmask;
  logic [NMEM*32-1:0] acc_rdata, nxt_rdata;
  logic [NMEM*32-1:0] acc_wdata, nxt_wdata;
  logic [NMEM-1:0]    acc_err,   nxt_err;
  logic [31:0]        rsp_rdata;
  logic               rsp_err;

`ifdef CV32E40X_RVFI_MEM_ERR_EN
  assign rsp_err   = data_err_i;
  assign rsp_rdata = data_err_i ? 32'h0 : data_rdata_i;
`else
  logic unused_data_err;
  assign unused_data_err = data_err_i;
  assign rsp_err   = 1'b0;
  assign rsp_rdata = data_rdata_i;
`endif

  always_comb begin
    nxt_cnt   = acc_cnt;
    nxt_ovf   = acc_ovf;
    nxt_addr  = acc_addr;
    nxt_rmask = acc_rmask;
    nxt_wmask = acc_wmask;
    nxt_rdata = acc_rdata;
    nxt_wdata = acc_wdata;
    nxt_err   = acc_err;
    if (append) begin
      if (acc_cnt == NMEM_C) begin
        nxt_ovf = 1'b1;
      end else begin
        nxt_addr [int'(acc_cnt)*32 +: 32] = head.addr;
        nxt_rmask[int'(acc_cnt)*4  +: 4]  = head.we ? 4'h0 : head.be;
        nxt_wmask[int'(acc_cnt)*4  +: 4]  = head.we ? head.be : 4'h0;
        nxt_rdata[int'(acc_cnt)*32 +: 32] = head.we ? 32'h0 : rsp_rdata;
        nxt_wdata[int'(acc_cnt)*32 +: 32] = head.we ? head.wdata : 32'h0;
        nxt_err  [int'(acc_cnt)]          = rsp_err;
        nxt_cnt  = acc_cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_cnt   <= '0;
      acc_ovf   <= 1'b0;
      acc_addr  <= '0;
      acc_rmask <= '0;
      acc_wmask <= '0;
      acc_rdata <= '0;
      acc_wdata <= '0;
      acc_err   <= '0;
    end else if (wb_retire_i || wb_flush_i) begin
      // Clearing to zero keeps unused slots at 0 in the next report.
      acc_cnt   <= '0;
      acc_ovf   <= 1'b0;
      acc_addr  <= '0;
      acc_rmask <= '0;
      acc_wmask <= '0;
      acc_rdata <= '0;
      acc_wdata <= '0;
      acc_err   <= '0;
    end else begin
      acc_cnt   <= nxt_cnt;
      acc_ovf   <= nxt_ovf;
      acc_addr  <= nxt_addr;
      acc_rmask <= nxt_rmask;
      acc_wmask <= nxt_wmask;
      acc_rdata <= nxt_rdata;
      acc_wdata <= nxt_wdata;
      acc_err   <= nxt_err;
    end
  end

  logic [NMEM-1:0] out_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvfi_mem_valid_o <= 1'b0;
      rvfi_mem_cnt_o   <= '0;
      rvfi_mem_ovf_o   <= 1'b0;
      rvfi_mem_addr_o  <= '0;
      rvfi_mem_rmask_o <= '0;
      rvfi_mem_wmask_o <= '0;
      rvfi_mem_rdata_o <= '0;
      rvfi_mem_wdata_o <= '0;
      out_err          <= '0;
      proto_err_o      <= 1'b0;
    end else begin
      rvfi_mem_valid_o <= wb_retire_i;
      if (wb_retire_i) begin
        rvfi_mem_cnt_o   <= nxt_cnt;
        rvfi_mem_ovf_o   <= nxt_ovf;
        rvfi_mem_addr_o  <= nxt_addr;
        rvfi_mem_rmask_o <= nxt_rmask;
        rvfi_mem_wmask_o <= nxt_wmask;
        rvfi_mem_rdata_o <= nxt_rdata;
        rvfi_mem_wdata_o <= nxt_wdata;
        out_err          <= nxt_err;
      end
      if ((data_rvalid_i && empty) || (accept && full && !pop)) begin
        proto_err_o <= 1'b1;
      end
    end
  end

`ifdef CV32E40X_RVFI_MEM_ERR_EN
  assign rvfi_mem_err_o = out_err;
`else
  logic [NMEM-1:0] unused_out_err;
  assign unused_out_err = out_err;
  assign rvfi_mem_err_o = '0;
`endif

endmodule

// File: tb/tb_cv32e40x_rvfi_mem_trace.sv
// tb/tb_cv32e40x_rvfi_mem_trace.sv - directed self-checking bench for cv32e40x_rvfi_mem_trace
module tb_cv32e40x_rvfi_mem_trace;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         data_req_i, data_gnt_i, data_we_i;
  logic [31:0]  data_addr_i, data_wdata_i, data_rdata_i;
  logic [3:0]   data_be_i;
  logic         data_rvalid_i, data_err_i, wb_retire_i, wb_flush_i;
  logic         rvfi_mem_valid_o, rvfi_mem_ovf_o, proto_err_o;
  logic [2:0]   rvfi_mem_cnt_o;
  logic [127:0] rvfi_mem_addr_o, rvfi_mem_rdata_o, rvfi_mem_wdata_o;
  logic [15:0]  rvfi_mem_rmask_o, rvfi_mem_wmask_o;
  logic [3:0]   rvfi_mem_err_o;

  int n_checks = 0;
  int n_fail   = 0;

  cv32e40x_rvfi_mem_trace #(.NMEM(4), .DEPTH(2)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .data_req_i       (data_req_i),
    .data_gnt_i       (data_gnt_i),
    .data_addr_i      (data_addr_i),
    .data_we_i        (data_we_i),
    .data_be_i        (data_be_i),
    .data_wdata_i     (data_wdata_i),
    .data_rvalid_i    (data_rvalid_i),
    .data_rdata_i     (data_rdata_i),
    .data_err_i       (data_err_i),
    .wb_retire_i      (wb_retire_i),
    .wb_flush_i       (wb_flush_i),
    .rvfi_mem_valid_o (rvfi_mem_valid_o),
    .rvfi_mem_cnt_o   (rvfi_mem_cnt_o),
    .rvfi_mem_addr_o  (rvfi_mem_addr_o),
    .rvfi_mem_rmask_o (rvfi_mem_rmask_o),
    .rvfi_mem_wmask_o (rvfi_mem_wmask_o),
    .rvfi_mem_rdata_o (rvfi_mem_rdata_o),
    .rvfi_mem_wdata_o (rvfi_mem_wdata_o),
    .rvfi_mem_err_o   (rvfi_mem_err_o),
    .rvfi_mem_ovf_o   (rvfi_mem_ovf_o),
    .proto_err_o      (proto_err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    data_req_i    = 1'b0;
    data_gnt_i    = 1'b0;
    data_addr_i   = 32'h0;
    data_we_i     = 1'b0;
    data_be_i     = 4'h0;
    data_wdata_i  = 32'h0;
    data_rvalid_i = 1'b0;
    data_rdata_i  = 32'h0;
    data_err_i    = 1'b0;
    wb_retire_i   = 1'b0;
    wb_flush_i    = 1'b0;
  endtask

  task automatic req(input logic [31:0] a, input logic w, input logic [3:0] b, input logic [31:0] wd);
    data_req_i   = 1'b1;
    data_gnt_i   = 1'b1;
    data_addr_i  = a;
    data_we_i    = w;
    data_be_i    = b;
    data_wdata_i = wd;
  endtask

  task automatic rsp(input logic [31:0] rd, input logic e);
    data_rvalid_i = 1'b1;
    data_rdata_i  = rd;
    data_err_i    = e;
  endtask

  // Clock the driven inputs in, then sample 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", 32'(rvfi_mem_valid_o), 0);
    chk("reset_cnt",   32'(rvfi_mem_cnt_o), 0);
    chk("reset_addr0", rvfi_mem_addr_o[31:0], 0);
    chk("reset_proto", 32'(proto_err_o), 0);
    rst_n = 1'b1;
    tick();

    // Store, response, retire
    req(32'h1000, 1'b1, 4'hF, 32'hDEADBEEF); tick();
    rsp(32'h12345678, 1'b0); tick();
    wb_retire_i = 1'b1; tick();
    chk("st_valid",  32'(rvfi_mem_valid_o), 1);
    chk("st_cnt",    32'(rvfi_mem_cnt_o), 1);
    chk("st_addr0",  rvfi_mem_addr_o[31:0], 32'h1000);
    chk("st_wmask0", 32'(rvfi_mem_wmask_o[3:0]), 32'hF);
    chk("st_rmask0", 32'(rvfi_mem_rmask_o[3:0]), 0);
    chk("st_wdata0", rvfi_mem_wdata_o[31:0], 32'hDEADBEEF);
    chk("st_rdata0", rvfi_mem_rdata_o[31:0], 0);
    tick();
    chk("st_pulse",  32'(rvfi_mem_valid_o), 0);

    // Misaligned load split in two, second response in the retire cycle
    req(32'h1003, 1'b0, 4'h8, 32'h0); tick();
    req(32'h1004, 1'b0, 4'h7, 32'h0); tick();
    rsp(32'hAA000000, 1'b0); tick();
    rsp(32'h00BBCCDD, 1'b0); wb_retire_i = 1'b1; tick();
    chk("mis_cnt",    32'(rvfi_mem_cnt_o), 2);
    chk("mis_addr0",  rvfi_mem_addr_o[31:0], 32'h1003);
    chk("mis_addr1",  rvfi_mem_addr_o[63:32], 32'h1004);
    chk("mis_rmask",  32'(rvfi_mem_rmask_o), 32'h0078);
    chk("mis_wmask",  32'(rvfi_mem_wmask_o), 0);
    chk("mis_rdata0", rvfi_mem_rdata_o[31:0], 32'hAA000000);
    chk("mis_rdata1", rvfi_mem_rdata_o[63:32], 32'h00BBCCDD);
    chk("mis_addr2",  rvfi_mem_addr_o[95:64], 0);
    chk("mis_ovf",    32'(rvfi_mem_ovf_o), 0);

    // Five load responses bound to one instruction: slot 4 dropped, overflow flagged
    req(32'h100, 1'b0, 4'hF, 32'h0); tick();
    for (int i = 1; i < 5; i++) begin
      req(32'h100 + 32'(4 * i), 1'b0, 4'hF, 32'h0);
      rsp(32'hD0 + 32'(i - 1), 1'b0);
      tick();
    end
    rsp(32'hD4, 1'b0); tick();
    wb_retire_i = 1'b1; tick();
    chk("ovf_cnt",    32'(rvfi_mem_cnt_o), 4);
    chk("ovf_flag",   32'(rvfi_mem_ovf_o), 1);
    chk("ovf_addr3",  rvfi_mem_addr_o[127:96], 32'h10C);
    chk("ovf_rdata3", rvfi_mem_rdata_o[127:96], 32'hD3);
    wb_retire_i = 1'b1; tick();
    chk("ovf_next_valid", 32'(rvfi_mem_valid_o), 1);
    chk("ovf_next_cnt",   32'(rvfi_mem_cnt_o), 0);
    chk("ovf_next_flag",  32'(rvfi_mem_ovf_o), 0);

    // Flush before the response: the response is discarded
    req(32'h2000, 1'b0, 4'hF, 32'h0); tick();
    wb_flush_i = 1'b1; tick();
    rsp(32'h77, 1'b0); tick();
    wb_retire_i = 1'b1; tick();
    chk("fl_cnt",   32'(rvfi_mem_cnt_o), 0);
    chk("fl_addr0", rvfi_mem_addr_o[31:0], 0);
    chk("fl_proto", 32'(proto_err_o), 0);

    // Retire+flush+accept in one cycle: retirement reported, new entry survives
    req(32'h500, 1'b0, 4'hF, 32'h0); tick();
    rsp(32'h55, 1'b0); tick();
    req(32'h504, 1'b0, 4'hF, 32'h0); wb_retire_i = 1'b1; wb_flush_i = 1'b1; tick();
    chk("rf_cnt",   32'(rvfi_mem_cnt_o), 1);
    chk("rf_addr0", rvfi_mem_addr_o[31:0], 32'h500);
    rsp(32'h66, 1'b0); wb_retire_i = 1'b1; tick();
    chk("rf_new_cnt",   32'(rvfi_mem_cnt_o), 1);
    chk("rf_new_addr0", rvfi_mem_addr_o[31:0], 32'h504);
    chk("rf_new_rdata", rvfi_mem_rdata_o[31:0], 32'h66);

    // Load with bus error
    req(32'h3000, 1'b0, 4'hF, 32'h0); tick();
    rsp(32'hFFFF, 1'b1); wb_retire_i = 1'b1; tick();
    chk("err_cnt", 32'(rvfi_mem_cnt_o), 1);
`ifdef CV32E40X_RVFI_MEM_ERR_EN
    chk("err_flag0",  32'(rvfi_mem_err_o), 1);
    chk("err_rdata0", rvfi_mem_rdata_o[31:0], 0);
`else
    chk("err_flag0",  32'(rvfi_mem_err_o), 0);
    chk("err_rdata0", rvfi_mem_rdata_o[31:0], 32'hFFFF);
`endif

    // Full tracker with accept and response together: legal
    req(32'h400, 1'b0, 4'hF, 32'h0); tick();
    req(32'h404, 1'b0, 4'hF, 32'h0); tick();
    req(32'h408, 1'b0, 4'hF, 32'h0); rsp(32'h1, 1'b0); tick();
    chk("full_both_proto", 32'(proto_err_o), 0);
    rsp(32'h2, 1'b0); tick();
    rsp(32'h3, 1'b0); wb_retire_i = 1'b1; tick();
    chk("full_cnt",    32'(rvfi_mem_cnt_o), 3);
    chk("full_addr2",  rvfi_mem_addr_o[95:64], 32'h408);
    chk("full_rdata2", rvfi_mem_rdata_o[95:64], 32'h3);
    chk("full_proto",  32'(proto_err_o), 0);

    // Response with an empty tracker: sticky protocol error
    rsp(32'h9, 1'b0); tick();
    chk("proto_set", 32'(proto_err_o), 1);
    tick(); tick();
    chk("proto_hold", 32'(proto_err_o), 1);
    wb_retire_i = 1'b1; tick();
    chk("proto_ignored_cnt", 32'(rvfi_mem_cnt_o), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
